// File: rtl/button_event_sched.sv
// Per-button press/long/repeat/release gesture FSMs with a round-robin event arbiter.
// Define BTN_SCHED_AUTOREPEAT_EN to emit REPEAT events while a button stays in HELD.
module button_event_sched #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int N_BTN     = 4,
  parameter int LONG_MS   = 800,
  parameter int REPEAT_MS = 200
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_BTN-1:0]           btn_level,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(N_BTN)-1:0]   evt_id,
  output logic [1:0]                 evt_code,
  output logic [N_BTN-1:0]           overflow,
  input  logic                       ovf_clear
);

  localparam int TICK_DIV = CLK_FREQ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDW      = $clog2(N_BTN);
  localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] C_PRESS   = 2'd0;
  localparam logic [1:0] C_LONG    = 2'd1;
  localparam logic [1:0] C_REPEAT  = 2'd2;
  localparam logic [1:0] C_RELEASE = 2'd3;

  // state  | meaning
  // S_IDLE | released, waiting for a rising level
  // S_DOWN | pressed, counting ms ticks towards LONG
  // S_HELD | long press reached, counting ticks between repeats
  typedef enum logic [1:0] {S_IDLE, S_DOWN, S_HELD} state_t;

  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  state_t           r_state     [N_BTN];
  state_t           w_state_nxt [N_BTN];
  logic [HW-1:0]    r_hold      [N_BTN];
  logic [HW-1:0]    w_hold_nxt  [N_BTN];
  logic [1:0]       w_emit_code [N_BTN];
  logic [1:0]       r_pend_code [N_BTN];
  logic [1:0]       w_pend_code_nxt [N_BTN];
  logic [N_BTN-1:0] r_prev, w_emit, w_drain, w_ovf_set;
  logic [N_BTN-1:0] r_pend_full, w_pend_full_nxt, r_ovf;
  logic             r_evt_valid, w_load_ok, w_gnt_vld;
  logic [IDW-1:0]   r_evt_id, r_rr, w_gnt_id;
  logic [1:0]       r_evt_code;

  function automatic logic [HW-1:0] f_sat_inc(input logic [HW-1:0] v);
    return (v == {HW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N_BTN) s = s - N_BTN;
    return IDW'(s);
  endfunction

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= S_IDLE;
        r_hold[i]  <= '0;
      end
    end else begin
      r_prev <= btn_level;
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_hold[i]  <= w_hold_nxt[i];
      end
    end
  end

  // A release always wins over a tick-driven LONG/REPEAT in the same cycle.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_hold_nxt[i]  = r_hold[i];
      w_emit[i]      = 1'b0;
      w_emit_code[i] = C_PRESS;
      case (r_state[i])
        S_IDLE: begin
          if (btn_level[i] && !r_prev[i]) begin
            w_state_nxt[i] = S_DOWN;
            w_hold_nxt[i]  = '0;
            w_emit[i]      = 1'b1;
            w_emit_code[i] = C_PRESS;
          end
        end
        S_DOWN: begin
          if (!btn_level[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_emit[i]      = 1'b1;
            w_emit_code[i] = C_RELEASE;
          end else if (w_tick) begin
            if (r_hold[i] == HW'(LONG_MS - 1)) begin
              w_state_nxt[i] = S_HELD;
              w_hold_nxt[i]  = '0;
              w_emit[i]      = 1'b1;
              w_emit_code[i] = C_LONG;
            end else begin
              w_hold_nxt[i] = f_sat_inc(r_hold[i]);
            end
          end
        end
        S_HELD: begin
          if (!btn_level[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_emit[i]      = 1'b1;
            w_emit_code[i] = C_RELEASE;
          end else if (w_tick) begin
`ifdef BTN_SCHED_AUTOREPEAT_EN
            if (r_hold[i] == HW'(REPEAT_MS - 1)) begin
              w_hold_nxt[i]  = '0;
              w_emit[i]      = 1'b1;
              w_emit_code[i] = C_REPEAT;
            end else begin
              w_hold_nxt[i] = f_sat_inc(r_hold[i]);
            end
`else
            w_hold_nxt[i] = f_sat_inc(r_hold[i]);
`endif
          end
        end
        default: w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  // A slot drained by the arbiter this cycle can accept a new event without overflow.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_ovf_set[i]       = 1'b0;
      w_pend_full_nxt[i] = r_pend_full[i];
      w_pend_code_nxt[i] = r_pend_code[i];
      if (w_drain[i]) w_pend_full_nxt[i] = 1'b0;
      if (w_emit[i]) begin
        if (r_pend_full[i] && !w_drain[i]) begin
          w_ovf_set[i] = 1'b1;
        end else begin
          w_pend_full_nxt[i] = 1'b1;
          w_pend_code_nxt[i] = w_emit_code[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_full <= '0;
      r_ovf       <= '0;
      for (int i = 0; i < N_BTN; i++) r_pend_code[i] <= C_PRESS;
    end else begin
      r_pend_full <= w_pend_full_nxt;
      r_ovf       <= (r_ovf & ~{N_BTN{ovf_clear}}) | w_ovf_set;
      for (int i = 0; i < N_BTN; i++) r_pend_code[i] <= w_pend_code_nxt[i];
    end
  end

  assign w_load_ok = !r_evt_valid || evt_ready;

  // Scan from the far end so the slot nearest the rr pointer is the last writer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (r_pend_full[f_wrap(r_rr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = f_wrap(r_rr, k);
      end
    end
  end

  assign w_drain = (w_load_ok && w_gnt_vld) ? (N_BTN'(1) << w_gnt_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_code  <= C_PRESS;
      r_rr        <= '0;
    end else if (w_load_ok) begin
      if (w_gnt_vld) begin
        r_evt_valid <= 1'b1;
        r_evt_id    <= w_gnt_id;
        r_evt_code  <= r_pend_code[w_gnt_id];
        r_rr        <= f_wrap(w_gnt_id, 1);
      end else begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_code  = r_evt_code;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_button_event_sched.sv
// Directed bench for button_event_sched: per-cycle vector table plus long-hold and reset sequences.
module tb_button_event_sched;

  logic       clk, rst_n, evt_ready, ovf_clear, evt_valid;
  logic [3:0] btn_level, overflow;
  logic [1:0] evt_id, evt_code;
  int         n_chk = 0, n_err = 0, cyc;

  button_event_sched #(
    .CLK_FREQ(10_000), .N_BTN(4), .LONG_MS(5), .REPEAT_MS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_code(evt_code), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic       clr;
    int         n;
    logic       ev;
    logic [1:0] id;
    logic [1:0] code;
    logic [3:0] ovf;
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [1:0]  code;
    logic [31:0] off;
  } evt_t;

  vec_t vecs[$];
  evt_t got[$];
  evt_t exp_q[$];

  task automatic add(input logic [3:0] b, input logic r, input logic c, input int n,
                     input logic ev, input logic [1:0] id, input logic [1:0] code,
                     input logic [3:0] ovf);
    vec_t v;
    v.btn = b; v.rdy = r; v.clr = c; v.n = n; v.ev = ev; v.id = id; v.code = code; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0; btn_level = '0; evt_ready = 1'b1; ovf_clear = 1'b0;

    // round robin from rr=0: 0,2,3; then rr=3: 3,0,2
    add(4'b1101, 0, 0, 1, 0, 0, 0, 4'h0);
    add(4'b1101, 0, 0, 4, 1, 0, 0, 4'h0);
    add(4'b1101, 1, 0, 1, 1, 2, 0, 4'h0);
    add(4'b1101, 1, 0, 1, 1, 3, 0, 4'h0);
    add(4'b1101, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b1000, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b1000, 1, 0, 1, 1, 0, 3, 4'h0);
    add(4'b1000, 1, 0, 1, 1, 2, 3, 4'h0);
    add(4'b1000, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0101, 0, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0101, 0, 0, 2, 1, 3, 3, 4'h0);
    add(4'b0101, 1, 0, 1, 1, 0, 0, 4'h0);
    add(4'b0101, 1, 0, 1, 1, 2, 0, 4'h0);
    add(4'b0101, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0000, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0000, 1, 0, 1, 1, 0, 3, 4'h0);
    add(4'b0000, 1, 0, 1, 1, 2, 3, 4'h0);
    add(4'b0000, 1, 0, 2, 0, 0, 0, 4'h0);
    // short press on button 1
    add(4'b0010, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0010, 1, 0, 1, 1, 1, 0, 4'h0);
    add(4'b0010, 1, 0, 28, 0, 0, 0, 4'h0);
    add(4'b0000, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0000, 1, 0, 1, 1, 1, 3, 4'h0);
    add(4'b0000, 1, 0, 3, 0, 0, 0, 4'h0);
    // overflow under backpressure, then clear
    add(4'b0001, 0, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0000, 0, 0, 1, 1, 0, 0, 4'h0);
    add(4'b0001, 0, 0, 1, 1, 0, 0, 4'h1);
    add(4'b0001, 0, 0, 3, 1, 0, 0, 4'h1);
    add(4'b0001, 0, 1, 1, 1, 0, 0, 4'h0);
    add(4'b0001, 1, 0, 1, 1, 0, 3, 4'h0);
    add(4'b0001, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0000, 1, 0, 1, 0, 0, 0, 4'h0);
    add(4'b0000, 1, 0, 1, 1, 0, 3, 4'h0);
    add(4'b0000, 1, 0, 2, 0, 0, 0, 4'h0);

    repeat (3) @(negedge clk);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_id", evt_id, 2'd0);
    chk("rst_code", evt_code, 2'd0);
    chk("rst_ovf", overflow, 4'h0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      btn_level = vecs[v].btn; evt_ready = vecs[v].rdy; ovf_clear = vecs[v].clr;
      for (int c = 0; c < vecs[v].n; c++) begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d_valid", v), evt_valid, vecs[v].ev);
        if (vecs[v].ev) begin
          chk($sformatf("vec%0d_id", v), evt_id, vecs[v].id);
          chk($sformatf("vec%0d_code", v), evt_code, vecs[v].code);
        end
        chk($sformatf("vec%0d_ovf", v), overflow, vecs[v].ovf);
      end
    end
    ovf_clear = 1'b0;

    // long hold on button 2, rise sampled one edge after a tick
    for (int g = 0; g < 20 && (cyc % 10) != 0; g++) @(negedge clk);
    begin
      int r0;
      r0 = cyc + 1;
      btn_level = 4'b0100; evt_ready = 1'b1;
      for (int j = 1; j <= 140; j++) begin
        @(negedge clk);
        if (evt_valid) got.push_back({evt_id, evt_code, 32'(cyc - r0)});
        if (cyc - r0 == 119) btn_level = 4'b0000;
      end
    end
    exp_q.push_back({2'd2, 2'd0, 32'd1});
    exp_q.push_back({2'd2, 2'd1, 32'd50});
`ifdef BTN_SCHED_AUTOREPEAT_EN
    exp_q.push_back({2'd2, 2'd2, 32'd70});
    exp_q.push_back({2'd2, 2'd2, 32'd90});
    exp_q.push_back({2'd2, 2'd2, 32'd110});
`endif
    exp_q.push_back({2'd2, 2'd3, 32'd121});
    chk("long_count", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("long_evt%0d", i), got[i], exp_q[i]);

    // reset while button 1 is HELD with LONG pending behind a stalled PRESS
    for (int g = 0; g < 20 && (cyc % 10) != 0; g++) @(negedge clk);
    btn_level = 4'b0010; evt_ready = 1'b0;
    repeat (60) @(negedge clk);
    chk("hold_valid", evt_valid, 1'b1);
    chk("hold_id", evt_id, 2'd1);
    chk("hold_code", evt_code, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", evt_valid, 1'b0);
    chk("async_id", evt_id, 2'd0);
    chk("async_code", evt_code, 2'd0);
    chk("async_ovf", overflow, 4'h0);
    @(negedge clk);
    rst_n = 1'b1; evt_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_e1_valid", evt_valid, 1'b0);
    @(negedge clk);
    chk("post_rst_valid", evt_valid, 1'b1);
    chk("post_rst_id", evt_id, 2'd1);
    chk("post_rst_code", evt_code, 2'd0);
    @(negedge clk);
    chk("post_rst_no_long", evt_valid, 1'b0);
    btn_level = 4'b0000;
    @(negedge clk);
    chk("post_rst_rel_wait", evt_valid, 1'b0);
    @(negedge clk);
    chk("post_rst_rel_valid", evt_valid, 1'b1);
    chk("post_rst_rel", {evt_id, evt_code}, {2'd1, 2'd3});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_sched.md
Name: button_event_sched

Overview:
- Per-button gesture controller and event arbiter for N debounced button levels.
- Runs a press/long-press/auto-repeat/release state machine per button.
- Holds at most one pending event per button, round-robin arbitrates pending events onto a single valid/ready event stream.
- Sits between the per-pin debouncers (stable level outputs) and the UI/menu logic.

Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz; CLK_FREQ/1000 must be >= 1.
- N_BTN, 4: number of buttons, 2..16.
- LONG_MS, 800: hold time in ms before a LONG event.
- REPEAT_MS, 200: REPEAT period in ms after LONG; must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- btn_level  input  N_BTN  debounced stable levels, 1 = pressed, synchronous to clk
- evt_valid  output  1  event available
- evt_ready  input  1  consumer accepts event when evt_valid && evt_ready
- evt_id  output  $clog2(N_BTN)  index of button that produced the event
- evt_code  output  2  0=PRESS, 1=LONG, 2=REPEAT, 3=RELEASE
- overflow  output  N_BTN  sticky per-button "event dropped" flags
- ovf_clear  input  1  synchronous clear of all overflow bits

Behaviour:
- Reset values: evt_valid=0, evt_id=0, evt_code=0, overflow=0. Internally: all FSMs IDLE, prev levels=0, pending empty, rr pointer=0, tick counter=0.
- Reset asserted mid-operation drops all pending and in-flight events immediately.
- ms tick:
  - Free-running counter 0..CLK_FREQ/1000-1.
  - tick=1 for one cycle when the counter wraps.
- Per-button FSM, states IDLE, DOWN, HELD; hold counter counts ticks and saturates.
  - IDLE: btn_level rising (level=1, prev=0) -> DOWN, hold counter=0, emit PRESS.
  - DOWN: on tick, hold counter +1. When it reaches LONG_MS -> HELD, hold counter=0, emit LONG.
  - HELD: on tick, hold counter +1. When it reaches REPEAT_MS -> hold counter=0, emit REPEAT.
  - DOWN or HELD: level falling -> IDLE, emit RELEASE. A fall takes priority over a tick-driven LONG/REPEAT in the same cycle; only RELEASE is emitted.
- Pending slot (one per button):
  - An emitted event loads the slot on the same clock edge.
  - Slot full and not being drained this cycle -> new event dropped, overflow[i] set.
  - Slot drained this cycle and a new event arrives -> new event loads with no overflow.
- Arbitration and output register:
  - Output register is loadable when evt_valid=0 or a handshake occurs this cycle.
  - When loadable, grant the first full slot at index >= rr pointer, wrapping modulo N_BTN.
  - On grant: load evt_id/evt_code, set evt_valid, clear that slot, set rr pointer = grant+1 mod N_BTN.
  - No full slot -> evt_valid goes to 0 after a handshake.
  - evt_id/evt_code are stable while evt_valid && !evt_ready.
  - Back-to-back throughput: one event per cycle.
- Latency: level edge at btn_level in cycle t -> slot full after edge t -> evt_valid=1 after edge t+1, i.e. 2 cycles, when the output is free.
- ovf_clear clears all overflow bits; a same-cycle set wins over the clear.

Optional Feature:
- Macro BTN_SCHED_AUTOREPEAT_EN.
- Defined: HELD emits REPEAT every REPEAT_MS as described above.
- Undefined: HELD emits nothing until release; the REPEAT_MS parameter is ignored and code 2 is never produced.

Test Plan:
- Common bench settings: CLK_FREQ=10_000 (tick every 10 cycles), N_BTN=4, LONG_MS=5, REPEAT_MS=2, evt_ready=1 unless stated.
- Short press: btn_level[1] high 30 cycles, then low -> PRESS id=1 two cycles after the rise, then RELEASE id=1; no LONG.
- Long hold with macro defined: btn_level[2] high 120 cycles -> PRESS, LONG (~50 cycles after the rise), then REPEAT every 20 cycles, then RELEASE on the fall.
- Long hold with macro undefined: same stimulus -> PRESS, LONG, RELEASE only.
- Round-robin fairness: evt_ready=0, raise btn_level[0], [2], [3] in the same cycle, then evt_ready=1 -> events in id order 0, 2, 3, each valid exactly one cycle. Repeat with rr pointer=3 -> order 3, 0, 2.
- Overflow and backpressure:
  - evt_ready=0; pulse btn_level[0] rise, fall, rise.
  - Required: first PRESS held in the output with payload stable; RELEASE pending; second PRESS dropped; overflow[0]=1.
  - Assert ovf_clear -> overflow[0]=0.
- Reset mid-hold: assert rst_n=0 while button 1 is in HELD with an event pending -> all outputs zero asynchronously; after release of reset with level still high -> fresh PRESS id=1.
